// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC/NPC sequencer with delay-slot semantics, stall freeze and a redirect buffer.
// Define PC_TRAP_EN to enable the trap vector path and EPC capture.
module fetch_pc_sequencer #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC    = 'h80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              trap,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic [1:0]        pc_source,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] epc
);

    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);
    localparam logic [1:0] SRC_SEQ = 2'b00, SRC_BRANCH = 2'b01, SRC_JUMP = 2'b10, SRC_ALT = 2'b11;

    typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, r_npc, r_ptgt, r_epc;
    logic [ADDR_W-1:0] w_pc_nxt, w_npc_nxt, w_ptgt_nxt, w_epc_nxt, w_redir_tgt;
    logic [1:0]        r_src, w_src_nxt, w_redir_src;
    logic              w_redir, w_trap;

`ifdef PC_TRAP_EN
    assign w_trap = trap;
`else
    // Trap is still read so the port stays connected, but it can never fire.
    assign w_trap = trap & 1'b0;
`endif

    always_comb begin
        w_redir     = jump | branch_taken;
        w_redir_tgt = (jump ? jump_target : branch_target) & ALIGN_MASK;
        w_redir_src = jump ? SRC_JUMP : SRC_BRANCH;
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_npc_nxt   = r_npc;
        w_src_nxt   = r_src;
        w_ptgt_nxt  = r_ptgt;
        w_epc_nxt   = r_epc;
        if (w_trap) begin
            w_state_nxt = RUN;
            w_pc_nxt    = TRAP_VEC;
            w_npc_nxt   = TRAP_VEC + INC;
            w_epc_nxt   = r_pc;
            w_src_nxt   = SRC_ALT;
        end else if (stall) begin
            // Newest redirect during a stall replaces any earlier buffered one.
            if (w_redir) begin
                w_state_nxt = HOLD_PEND;
                w_ptgt_nxt  = w_redir_tgt;
            end else if (r_state == RUN) begin
                w_state_nxt = HOLD;
            end
        end else begin
            w_state_nxt = RUN;
            w_pc_nxt    = r_npc;
            if (w_redir) begin
                w_npc_nxt = w_redir_tgt;
                w_src_nxt = w_redir_src;
            end else if (r_state == HOLD_PEND) begin
                w_npc_nxt = r_ptgt;
                w_src_nxt = SRC_ALT;
            end else begin
                w_npc_nxt = r_npc + INC;
                w_src_nxt = SRC_SEQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_npc   <= RESET_PC + INC;
            r_src   <= SRC_SEQ;
            r_ptgt  <= '0;
            r_epc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_npc   <= w_npc_nxt;
            r_src   <= w_src_nxt;
            r_ptgt  <= w_ptgt_nxt;
            r_epc   <= w_epc_nxt;
        end
    end

    assign pc         = r_pc;
    assign npc        = r_npc;
    assign pc_source  = r_src;
    assign pend_valid = (r_state == HOLD_PEND);
    assign epc        = r_epc;

endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Parametrised PC/NPC sequencer for the fetch stage of the pipelined MIPS core. It holds the PC/NPC pair with delay-slot semantics and selects the next NPC from the sequential, branch or jump target. It freezes on pipeline stall and buffers any redirect that arrives while stalled so no redirect is lost. An optional trap vector path overrides everything. It feeds the instruction-memory address and the IF/ID pipeline register.

## Interface
- ADDR_W, 32, PC/target width in bits
- INSTR_BYTES, 4, sequential increment; power of two, ≥1
- RESET_PC, 0, PC value after reset
- TRAP_VEC, 32'h80, trap handler address (used only with PC_TRAP_EN)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  1 = hold PC/NPC this cycle
- branch_taken  in  1  branch resolved taken this cycle
- branch_target  in  ADDR_W  branch destination
- jump  in  1  jump this cycle
- jump_target  in  ADDR_W  jump destination
- trap  in  1  exception request (ignored without PC_TRAP_EN)
- pc  out  ADDR_W  current fetch address
- npc  out  ADDR_W  next fetch address
- pc_source  out  2  source of last NPC update: 00 seq, 01 branch, 10 jump, 11 trap/pending
- pend_valid  out  1  buffered redirect waiting
- epc  out  ADDR_W  PC captured at last trap (0 without PC_TRAP_EN)

## Operation
- Redirect priority: trap > jump > branch_taken > sequential. Redirect targets have their low log2(INSTR_BYTES) bits forced to 0.
- Sequential value is npc + INSTR_BYTES, modulo 2^ADDR_W. 0xFFFFFFFC+4 wraps to 0.
- Advance (stall=0): pc←npc; npc←selected target. The delay-slot instruction at the old npc therefore still executes.
- Advance with pend_valid=1 and no new redirect: npc←pending target, pc_source=11, pend cleared.
- Advance with pend_valid=1 and a new jump/branch: the new redirect wins and the pending target is discarded.
- Stall=1: pc and npc hold. A jump/branch asserted during the stall is latched into the pending register and pend_valid is set.
- A later redirect during the same stall overwrites the pending target (newest wins). Within a single cycle, jump is chosen over branch.
- State machine:
  - RUN: default state.
  - HOLD: stall=1, nothing pending.
  - HOLD_PEND: stall=1, redirect pending.
  - RUN→HOLD on stall. RUN→HOLD_PEND on stall together with a redirect. HOLD→HOLD_PEND on a redirect.
  - HOLD/HOLD_PEND→RUN when stall falls, applying the pending target as above.
- Trap (with macro): takes effect in any state, including while stalled. pc←TRAP_VEC, npc←TRAP_VEC+INSTR_BYTES, epc←pc, pc_source=11, pend cleared, state→RUN.
- Reset values: pc=RESET_PC, npc=RESET_PC+INSTR_BYTES, pc_source=00, pend_valid=0, epc=0, state=RUN.
- Reset overrides every other input, including in mid-stall or pending states.

## Timing
- All state updates happen on the posedge clk. pc, npc, pc_source, pend_valid and epc are all registered.
- Redirect in cycle N (unstalled): npc = target after edge N; pc = target after edge N+1.
- Redirect latched during a stall: npc = target one edge after stall deasserts.
- pend_valid rises the edge after the redirect is captured and falls on the release edge.
- Trap: pc = TRAP_VEC after the same edge, 1-cycle latency.
- Stall and redirect asserted together is legal; the redirect is buffered, never dropped.

## Configuration
- PC_TRAP_EN defined: trap path, TRAP_VEC and epc capture are active.
- PC_TRAP_EN undefined: the trap input is ignored, epc is tied to 0, and pc_source=11 only ever means a pending redirect was applied. Ports remain, so instantiations are identical.

## Test plan
- Reset then 3 free cycles → pc 0,4,8,C; npc 4,8,C,10; pc_source 00.
- jump=1, jump_target=0x100 at pc=0x8 → next edge npc=0x100 (pc=0xC delay slot), following edge pc=0x100, pc_source=10.
- Same cycle: jump=1 (0x200) and branch_taken=1 (0x300) → npc=0x200.
- stall=1 for 4 cycles, branch_taken=1 (0x40) in cycle 2 → pc/npc frozen, pend_valid=1. On release, npc=0x40, pc_source=11, pend_valid=0.
- Stall with pending 0x40, then a jump to 0x500 during the stall → released npc=0x500. Separately, pending 0x40 and a new branch to 0x600 on the release cycle → npc=0x600.
- With PC_TRAP_EN: trap while stalled at pc=0x24 → pc=0x80, npc=0x84, epc=0x24, pend cleared. Also: pc=0xFFFFFFFC sequential → npc wraps to 0x0.
